alu_seq_mc: RTL and testbench

//  Parametrised, handshaked successor to the 16-bit combinational datapath ALU.

---
 rtl/alu_seq_mc.sv | 183 ++++++++++++++++++
 tb/tb_alu_seq_mc.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_mc.sv
// alu_seq_mc: handshaked datapath ALU with registered result/flags and an
// iterative shift-add multiplier. Single-cycle ops finish in one edge; MUL
// holds the input side off while it walks the multiplier one bit per cycle.
module alu_seq_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             z,
  output logic             v,
  output logic             n,
  output logic             c,
  output logic             err
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] CNT_DONE = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NAND = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_INC  = 4'd4;
  localparam logic [3:0] OP_SRA  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_ROL  = 4'd9;
  localparam logic [3:0] OP_ROR  = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               state_r;
  logic [2*WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [CW-1:0]        cnt_r;

  logic                 accept_s;
  logic [SHW-1:0]       sh_s;
  logic [WIDTH:0]       add_s;
  logic [WIDTH:0]       sub_s;
  logic [WIDTH-1:0]     sra_s;
  logic [2*WIDTH-1:0]   rol_full_s;
  logic [2*WIDTH-1:0]   ror_full_s;
  logic [2*WIDTH-1:0]   addend_s;
  logic [WIDTH-1:0]     res_s;
  logic                 z_s, v_s, n_s, c_s, err_s;

  // A new op can enter when idle, or when the held result leaves this same cycle.
  assign in_ready = (state_r == IDLE) | ((state_r == HOLD) & out_ready);
  assign accept_s = in_valid & in_ready;

  assign sh_s       = alu_b[SHW-1:0];
  assign add_s      = {1'b0, alu_a} + {1'b0, alu_b};
  assign sub_s      = {1'b0, alu_a} - {1'b0, alu_b};
  assign sra_s      = WIDTH'($signed(alu_a) >>> sh_s);
  // Rotates: shift a doubled copy so the bits falling off one end reappear.
  assign rol_full_s = {alu_a, alu_a} << sh_s;
  assign ror_full_s = {alu_a, alu_a} >> sh_s;
  assign addend_s   = mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}};

  // Single-cycle result and flag computation from the presented operands.
  always_comb begin
    res_s = {WIDTH{1'b0}};
    v_s   = 1'b0;
    n_s   = 1'b0;
    c_s   = 1'b0;
    err_s = 1'b0;
    case (alu_op)
      OP_ADD, OP_INC: begin
        res_s = add_s[WIDTH-1:0];
        c_s   = add_s[WIDTH];
        v_s   = (alu_a[MSB] == alu_b[MSB]) && (add_s[MSB] != alu_a[MSB]);
        n_s   = add_s[MSB];
      end
      OP_SUB: begin
        res_s = sub_s[WIDTH-1:0];
        c_s   = ~sub_s[WIDTH];
        v_s   = (alu_a[MSB] != alu_b[MSB]) && (sub_s[MSB] != alu_a[MSB]);
        n_s   = sub_s[MSB];
      end
      OP_NAND: res_s = ~(alu_a & alu_b);
      OP_XOR:  res_s = alu_a ^ alu_b;
      OP_SRA:  res_s = sra_s;
      OP_SRL:  res_s = alu_a >> sh_s;
      OP_SLL:  res_s = alu_a << sh_s;
      OP_ROL:  res_s = rol_full_s[2*WIDTH-1:WIDTH];
      OP_ROR:  res_s = ror_full_s[WIDTH-1:0];
      OP_MUL:  res_s = {WIDTH{1'b0}};
      default: err_s = 1'b1;
    endcase
    z_s = (res_s == {WIDTH{1'b0}});
  end

  // Control FSM, multiplier datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      out_valid  <= 1'b0;
      alu_result <= {WIDTH{1'b0}};
      z          <= 1'b0;
      v          <= 1'b0;
      n          <= 1'b0;
      c          <= 1'b0;
      err        <= 1'b0;
      mcand_r    <= {(2*WIDTH){1'b0}};
      mplier_r   <= {WIDTH{1'b0}};
      acc_r      <= {(2*WIDTH){1'b0}};
      cnt_r      <= {CW{1'b0}};
    end else if (accept_s) begin
      if (alu_op == OP_MUL) begin
        mcand_r   <= {{WIDTH{1'b0}}, alu_a};
        mplier_r  <= alu_b;
        acc_r     <= {(2*WIDTH){1'b0}};
        cnt_r     <= {CW{1'b0}};
        out_valid <= 1'b0;
        state_r   <= BUSY;
      end else begin
        alu_result <= res_s;
        z          <= z_s;
        v          <= v_s;
        n          <= n_s;
        c          <= c_s;
        err        <= err_s;
        out_valid  <= 1'b1;
        state_r    <= HOLD;
      end
    end else begin
      case (state_r)
        IDLE: begin
          out_valid <= 1'b0;
        end
        BUSY: begin
          // WIDTH iteration edges, then one more edge to publish the product.
          if (cnt_r == CNT_DONE) begin
            alu_result <= acc_r[WIDTH-1:0];
            z          <= (acc_r[WIDTH-1:0] == {WIDTH{1'b0}});
            v          <= |acc_r[2*WIDTH-1:WIDTH];
            n          <= 1'b0;
            c          <= 1'b0;
            err        <= 1'b0;
            out_valid  <= 1'b1;
            state_r    <= HOLD;
          end else begin
            acc_r    <= acc_r + addend_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CNT_ONE;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_mc.sv
// Directed testbench for alu_seq_mc (WIDTH=16).
module tb_alu_seq_mc;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] alu_result;
  logic        z, v, n, c, err;

  int n_checks;
  int n_errors;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  zvnc;
    logic        err;
  } vec_t;

  vec_t tbl [14];

  alu_seq_mc #(.WIDTH(16), .SHW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .z          (z),
    .v          (v),
    .n          (n),
    .c          (c),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 4'd0; alu_a = 16'h0000; alu_b = 16'h0000;
    #1;
    n_checks++;
    if ({out_valid, alu_result, z, v, n, c, err} !== {1'b0, 16'h0000, 5'b00000}) begin
      n_errors++;
      $display("FAIL reset_outputs: got ov=%b res=%h zvnc=%b%b%b%b err=%b, want all zero", out_valid, alu_result, z, v, n, c, err);
    end
    tick(); tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_add();
    in_valid = 1'b1; alu_op = 4'd0; alu_a = 16'h7FFF; alu_b = 16'h0001; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, alu_result, z, v, n, c, err} !== {1'b1, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL add_ovf: got ov=%b res=%h zvnc=%b%b%b%b err=%b, want ov=1 res=8000 zvnc=0110 err=0", out_valid, alu_result, z, v, n, c, err);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL add_release: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; alu_op = 4'd1; alu_a = 16'h0005; alu_b = 16'h0005; out_ready = 1'b1;
    tick();
    n_checks++;
    if ({out_valid, alu_result, z, v, n, c, err, in_ready} !== {1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL b2b_sub: got ov=%b res=%h zvnc=%b%b%b%b err=%b rdy=%b, want ov=1 res=0000 zvnc=1001 err=0 rdy=1", out_valid, alu_result, z, v, n, c, err, in_ready);
    end
    alu_op = 4'd3; alu_a = 16'hFFFF; alu_b = 16'h00FF;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, alu_result, z, v, n, c, err, in_ready} !== {1'b1, 16'hFF00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL b2b_xor: got ov=%b res=%h zvnc=%b%b%b%b err=%b rdy=%b, want ov=1 res=FF00 zvnc=0000 err=0 rdy=1", out_valid, alu_result, z, v, n, c, err, in_ready);
    end
    tick();
  endtask

  task automatic test_mul();
    in_valid = 1'b1; alu_op = 4'd8; alu_a = 16'h0123; alu_b = 16'h0010; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if ({in_ready, out_valid} !== 2'b00) begin
        n_errors++;
        $display("FAIL mul_busy[%0d]: got rdy=%b ov=%b want 0 0", i, in_ready, out_valid);
      end
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL mul_early: out_valid got %b want 0 at edge 16", out_valid);
    end
    tick();
    n_checks++;
    if ({out_valid, alu_result, z, v, n, c, err} !== {1'b1, 16'h1230, 5'b00000}) begin
      n_errors++;
      $display("FAIL mul_1230: got ov=%b res=%h zvnc=%b%b%b%b err=%b, want ov=1 res=1230 zvnc=0000 err=0", out_valid, alu_result, z, v, n, c, err);
    end
    // second multiply accepted in the same cycle the first result leaves
    in_valid = 1'b1; alu_a = 16'h1000; alu_b = 16'h0100;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    n_checks++;
    if ({out_valid, alu_result, z, v, n, c, err} !== {1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL mul_ovf: got ov=%b res=%h zvnc=%b%b%b%b err=%b, want ov=1 res=0000 zvnc=1100 err=0", out_valid, alu_result, z, v, n, c, err);
    end
    tick();
  endtask

  task automatic test_ops();
    tbl[0]  = {4'd5,  16'h8000, 16'h0013, 16'hF000, 4'b0000, 1'b0};
    tbl[1]  = {4'd10, 16'h0001, 16'h0001, 16'h8000, 4'b0000, 1'b0};
    tbl[2]  = {4'd2,  16'hF0F0, 16'hFF00, 16'h0FFF, 4'b0000, 1'b0};
    tbl[3]  = {4'd6,  16'h8000, 16'h0004, 16'h0800, 4'b0000, 1'b0};
    tbl[4]  = {4'd7,  16'h0003, 16'h0004, 16'h0030, 4'b0000, 1'b0};
    tbl[5]  = {4'd9,  16'h8001, 16'h0001, 16'h0003, 4'b0000, 1'b0};
    tbl[6]  = {4'd4,  16'hFFFF, 16'h0001, 16'h0000, 4'b1001, 1'b0};
    tbl[7]  = {4'd1,  16'h0003, 16'h0005, 16'hFFFE, 4'b0010, 1'b0};
    tbl[8]  = {4'd1,  16'h8000, 16'h0001, 16'h7FFF, 4'b0101, 1'b0};
    tbl[9]  = {4'd0,  16'h8000, 16'h8000, 16'h0000, 4'b1101, 1'b0};
    tbl[10] = {4'd3,  16'hAAAA, 16'hAAAA, 16'h0000, 4'b1000, 1'b0};
    tbl[11] = {4'd5,  16'h7000, 16'h0002, 16'h1C00, 4'b0000, 1'b0};
    tbl[12] = {4'd9,  16'h1234, 16'h0010, 16'h1234, 4'b0000, 1'b0};
    tbl[13] = {4'd15, 16'h1234, 16'h5678, 16'h0000, 4'b1000, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; alu_op = tbl[i].op; alu_a = tbl[i].a; alu_b = tbl[i].b;
      tick();
      n_checks++;
      if ({out_valid, alu_result, z, v, n, c, err} !== {1'b1, tbl[i].res, tbl[i].zvnc, tbl[i].err}) begin
        n_errors++;
        $display("FAIL ops[%0d] op=%0d: got ov=%b res=%h zvnc=%b%b%b%b err=%b, want res=%h zvnc=%b err=%b", i, tbl[i].op, out_valid, alu_result, z, v, n, c, err, tbl[i].res, tbl[i].zvnc, tbl[i].err);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    in_valid = 1'b1; alu_op = 4'd0; alu_a = 16'h0001; alu_b = 16'h0002; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; alu_op = 4'd3; alu_a = 16'h00F0; alu_b = 16'h000F;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_rdy[%0d]: got %b want 0", i, in_ready);
      end
      tick();
      n_checks++;
      if ({out_valid, alu_result, z, v, n, c, err} !== {1'b1, 16'h0003, 5'b00000}) begin
        n_errors++;
        $display("FAIL stall_hold[%0d]: got ov=%b res=%h zvnc=%b%b%b%b err=%b, want ov=1 res=0003", i, out_valid, alu_result, z, v, n, c, err);
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_resume_rdy: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, alu_result} !== {1'b1, 16'h00FF}) begin
      n_errors++;
      $display("FAIL stall_next: got ov=%b res=%h want ov=1 res=00FF", out_valid, alu_result);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL stall_dup: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    in_valid = 1'b1; alu_op = 4'd8; alu_a = 16'h0003; alu_b = 16'h0003; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, alu_result, z, v, n, c, err} !== {1'b0, 16'h0000, 5'b00000}) begin
      n_errors++;
      $display("FAIL rst_mul: got ov=%b res=%h zvnc=%b%b%b%b err=%b, want all zero", out_valid, alu_result, z, v, n, c, err);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 18; i++) tick();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_errors++;
      $display("FAIL rst_no_result: got ov=%b rdy=%b want ov=0 rdy=1", out_valid, in_ready);
    end
    in_valid = 1'b1; alu_op = 4'd12; alu_a = 16'hBEEF; alu_b = 16'h1234;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, alu_result, z, v, n, c, err} !== {1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL illegal_op12: got ov=%b res=%h zvnc=%b%b%b%b err=%b, want ov=1 res=0000 zvnc=1000 err=1", out_valid, alu_result, z, v, n, c, err);
    end
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_add();
    test_back_to_back();
    test_mul();
    test_ops();
    test_stall();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
